bf_uart_loader: RTL and testbench

- Runtime program loader for the brainfuck system, a parametrised successor to the fixed-ROM system top.
- Receives ASCII source over the UART receive stream and filters it to the eight brainfuck characters.
- Encodes each character as a PROG_DATA_WIDTH opcode, writes it into program RAM and appends an END opcode.
- Checks bracket balance and holds the core in reset for the whole load; releases the core only after a clean load.

---
 rtl/bf_uart_loader.sv | 179 +++++++++++++++++
 tb/tb_bf_uart_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_loader.sv
// Runtime brainfuck program loader: filters UART bytes to opcodes, writes them to
// program RAM with a trailing END word, and holds the core in reset until a clean load.
module bf_uart_loader #(
    parameter int             PROG_ADDR_WIDTH = 8,
    parameter int             PROG_DATA_WIDTH = 4,
    parameter int             NEST_WIDTH      = 8,
    parameter logic [7:0]     END_CHAR        = 8'h21,
    parameter logic [3:0]     END_OPCODE      = 4'h8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
    output logic [PROG_DATA_WIDTH-1:0] prog_wr_data,
    output logic                       prog_wr_en,
    output logic                       core_rst,
    output logic                       rx_sel,
    output logic [PROG_ADDR_WIDTH-1:0] prog_len,
    output logic                       err_bracket,
    output logic                       err_overflow
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [PROG_ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [NEST_WIDTH-1:0]      DEPTH_MAX = '1;
    localparam logic [PROG_DATA_WIDTH-1:0] END_WORD = PROG_DATA_WIDTH'(END_OPCODE);

    state_t                     state_q, state_d;
    logic [PROG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NEST_WIDTH-1:0]      depth_q, depth_d;
    logic                       wr_en_q, wr_en_d;
    logic [PROG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [PROG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [PROG_ADDR_WIDTH-1:0] prog_len_q, prog_len_d;
    logic                       err_bracket_q, err_bracket_d;
    logic                       err_overflow_q, err_overflow_d;

    logic       is_op;
    logic [2:0] op;
    logic       accept;

    always_comb begin
        is_op = 1'b1;
        op    = 3'd0;
        case (rx_data)
            8'h3E:   op = 3'd0;
            8'h3C:   op = 3'd1;
            8'h2B:   op = 3'd2;
            8'h2D:   op = 3'd3;
            8'h2E:   op = 3'd4;
            8'h2C:   op = 3'd5;
            8'h5B:   op = 3'd6;
            8'h5D:   op = 3'd7;
            default: is_op = 1'b0;
        endcase
    end

    assign rx_ready = (state_q == LOAD);
    assign accept   = rx_valid && rx_ready;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        depth_d        = depth_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        prog_len_d     = prog_len_q;
        err_bracket_d  = err_bracket_q;
        err_overflow_d = err_overflow_q;

        case (state_q)
            RUN, ERROR: begin
                if (load_req) begin
                    state_d        = LOAD;
                    addr_d         = '0;
                    depth_d        = '0;
                    err_bracket_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over any byte presented in the same cycle
                if (load_req) begin
                    addr_d         = '0;
                    depth_d        = '0;
                    err_bracket_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end else if (accept) begin
                    if (rx_data == END_CHAR) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = END_WORD;
                        prog_len_d = addr_q;
                        if (depth_q != '0) begin
                            err_bracket_d = 1'b1;
                            state_d       = ERROR;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (is_op) begin
                        if ((op == 3'd6 && depth_q == DEPTH_MAX) ||
                            (op == 3'd7 && depth_q == '0)) begin
                            err_bracket_d = 1'b1;
                            state_d       = ERROR;
                        end else if (addr_q == ADDR_MAX) begin
                            // Last location is reserved, so terminate the image here
                            wr_en_d        = 1'b1;
                            wr_addr_d      = addr_q;
                            wr_data_d      = END_WORD;
                            prog_len_d     = ADDR_MAX;
                            err_overflow_d = 1'b1;
                            state_d        = ERROR;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = PROG_DATA_WIDTH'(op);
                            addr_d    = addr_q + PROG_ADDR_WIDTH'(1);
                            if (op == 3'd6) begin
                                depth_d = depth_q + NEST_WIDTH'(1);
                            end else if (op == 3'd7) begin
                                depth_d = depth_q - NEST_WIDTH'(1);
                            end
                        end
                    end
                end
            end
            FINISH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            addr_q         <= '0;
            depth_q        <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            prog_len_q     <= '0;
            err_bracket_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            depth_q        <= depth_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            prog_len_q     <= prog_len_d;
            err_bracket_q  <= err_bracket_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign prog_wr_en   = wr_en_q;
    assign prog_wr_addr = wr_addr_q;
    assign prog_wr_data = wr_data_q;
    assign prog_len     = prog_len_q;
    assign err_bracket  = err_bracket_q;
    assign err_overflow = err_overflow_q;
    assign core_rst     = (state_q != RUN);
    assign rx_sel       = core_rst;

endmodule

// File: tb/tb_bf_uart_loader.sv
// Scoreboard bench for bf_uart_loader: a default-sized instance plus a
// 3-bit-address instance for the overflow case.
module tb_bf_uart_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loadReqA = 1'b0;
    logic       loadReqB = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       rxValid = 1'b0;

    logic       rdyA, wrEnA, coreRstA, rxSelA, errBrA, errOvA;
    logic [7:0] wrAddrA, progLenA;
    logic [3:0] wrDataA;
    logic       rdyB, wrEnB, coreRstB, rxSelB, errBrB, errOvB;
    logic [2:0] wrAddrB, progLenB;
    logic [3:0] wrDataB;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wrPulses = 0;
    bit  selB = 1'b0;

    bf_uart_loader dutA (
        .clk(clk), .rst(rst), .load_req(loadReqA), .rx_data(rxData), .rx_valid(rxValid),
        .rx_ready(rdyA), .prog_wr_addr(wrAddrA), .prog_wr_data(wrDataA), .prog_wr_en(wrEnA),
        .core_rst(coreRstA), .rx_sel(rxSelA), .prog_len(progLenA),
        .err_bracket(errBrA), .err_overflow(errOvA)
    );

    bf_uart_loader #(.PROG_ADDR_WIDTH(3)) dutB (
        .clk(clk), .rst(rst), .load_req(loadReqB), .rx_data(rxData), .rx_valid(rxValid),
        .rx_ready(rdyB), .prog_wr_addr(wrAddrB), .prog_wr_data(wrDataB), .prog_wr_en(wrEnB),
        .core_rst(coreRstB), .rx_sel(rxSelB), .prog_len(progLenB),
        .err_bracket(errBrB), .err_overflow(errOvB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        wr_t        e;
        logic       en;
        logic [7:0] a;
        logic [3:0] d;
        en = selB ? wrEnB : wrEnA;
        a  = selB ? {5'd0, wrAddrB} : wrAddrA;
        d  = selB ? wrDataB : wrDataA;
        if (rst && en) begin
            wrPulses++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("wr_addr", a, e.addr);
                checkOutput("wr_data", d, e.data);
                checkOutput("wr_latency", cyc, e.cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit expRdy, input bit expWr,
                                 input int addr, input int data);
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        if (expWr) sb.push_back('{addr, data, cyc + 1});
        checkOutput("rx_ready", selB ? rdyB : rdyA, expRdy);
    endtask

    task automatic gapCycle();
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic loadReq(input bit withByte);
        @(negedge clk);
        if (selB) loadReqB = 1'b1;
        else      loadReqA = 1'b1;
        rxValid = withByte;
        rxData  = "+";
        @(negedge clk);
        loadReqA = 1'b0;
        loadReqB = 1'b0;
        rxValid  = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        checkOutput(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int p0;
        #12;
        checkOutput("rst_core_rst", coreRstA, 0);
        checkOutput("rst_rx_sel", rxSelA, 0);
        checkOutput("rst_rx_ready", rdyA, 0);
        checkOutput("rst_wr_en", wrEnA, 0);
        checkOutput("rst_wr_addr", wrAddrA, 0);
        checkOutput("rst_prog_len", progLenA, 0);
        checkOutput("rst_b_core_rst", coreRstB, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic load "+[-]!"
        loadReq(1'b0);
        checkOutput("load_core_rst", coreRstA, 1);
        checkOutput("load_rx_sel", rxSelA, 1);
        applyStimulus("+", 1, 1, 0, 2);
        applyStimulus("[", 1, 1, 1, 6);
        applyStimulus("-", 1, 1, 2, 3);
        applyStimulus("]", 1, 1, 3, 7);
        applyStimulus("!", 1, 1, 4, 8);
        gapCycle();
        checkOutput("finish_core_rst", coreRstA, 1);
        @(negedge clk);
        checkOutput("run_core_rst", coreRstA, 0);
        checkOutput("basic_prog_len", progLenA, 4);
        checkOutput("basic_err_br", errBrA, 0);
        checkOutput("basic_err_ov", errOvA, 0);
        drain("basic_sb_empty");

        // Comment filtering "a+ b\n>!"
        loadReq(1'b0);
        applyStimulus("a", 1, 0, 0, 0);
        applyStimulus("+", 1, 1, 0, 2);
        applyStimulus(" ", 1, 0, 0, 0);
        applyStimulus("b", 1, 0, 0, 0);
        applyStimulus(8'h0A, 1, 0, 0, 0);
        applyStimulus(">", 1, 1, 1, 0);
        applyStimulus("!", 1, 1, 2, 8);
        gapCycle();
        @(negedge clk);
        checkOutput("filter_prog_len", progLenA, 2);
        checkOutput("filter_core_rst", coreRstA, 0);
        drain("filter_sb_empty");

        // Unmatched close bracket: no write, error, later bytes ignored
        loadReq(1'b0);
        applyStimulus("]", 1, 0, 0, 0);
        applyStimulus("!", 0, 0, 0, 0);
        gapCycle();
        checkOutput("close_err_br", errBrA, 1);
        checkOutput("close_core_rst", coreRstA, 1);
        drain("close_sb_empty");

        // Unclosed bracket at end: END still written, then error
        loadReq(1'b0);
        checkOutput("reload_clears_err_br", errBrA, 0);
        applyStimulus("[", 1, 1, 0, 6);
        applyStimulus("[", 1, 1, 1, 6);
        applyStimulus("]", 1, 1, 2, 7);
        applyStimulus("!", 1, 1, 3, 8);
        gapCycle();
        @(negedge clk);
        checkOutput("open_err_br", errBrA, 1);
        checkOutput("open_core_rst", coreRstA, 1);
        checkOutput("open_rx_ready", rdyA, 0);
        checkOutput("open_prog_len", progLenA, 3);
        drain("open_sb_empty");

        // Restart: byte alongside load_req is dropped, next op lands at 0
        loadReq(1'b0);
        applyStimulus("+", 1, 1, 0, 2);
        applyStimulus("+", 1, 1, 1, 2);
        applyStimulus("+", 1, 1, 2, 2);
        loadReq(1'b1);
        applyStimulus("-", 1, 1, 0, 3);
        gapCycle();
        drain("restart_sb_empty");

        // Flow control: valid toggles every cycle
        loadReq(1'b0);
        p0 = wrPulses;
        applyStimulus("+", 1, 1, 0, 2);
        gapCycle();
        applyStimulus("-", 1, 1, 1, 3);
        gapCycle();
        applyStimulus("!", 1, 1, 2, 8);
        gapCycle();
        drain("flow_sb_empty");
        checkOutput("flow_pulses", wrPulses - p0, 3);

        // Reset mid-load
        loadReq(1'b0);
        applyStimulus("+", 1, 1, 0, 2);
        gapCycle();
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_core_rst", coreRstA, 0);
        checkOutput("midrst_rx_sel", rxSelA, 0);
        checkOutput("midrst_rx_ready", rdyA, 0);
        checkOutput("midrst_wr_en", wrEnA, 0);
        checkOutput("midrst_wr_addr", wrAddrA, 0);
        checkOutput("midrst_wr_data", wrDataA, 0);
        checkOutput("midrst_prog_len", progLenA, 0);
        @(negedge clk);
        rst = 1'b1;
        drain("midrst_sb_empty");

        // Overflow on the 3-bit instance
        selB = 1'b1;
        loadReq(1'b0);
        for (int i = 0; i < 7; i++) applyStimulus("+", 1, 1, i, 2);
        applyStimulus("+", 1, 1, 7, 8);
        gapCycle();
        @(negedge clk);
        checkOutput("ovf_err_ov", errOvB, 1);
        checkOutput("ovf_prog_len", progLenB, 7);
        checkOutput("ovf_core_rst", coreRstB, 1);
        checkOutput("ovf_rx_ready", rdyB, 0);
        drain("ovf_sb_empty");
        selB = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
